// File: rtl/uart_frame_loader_if.sv
// uart_frame_loader_if: byte stream in from the UART receiver, PROM write
// port and status out. Parametrised to match the loader's word and address
// widths.
//
// Handshake: rx_ready_i is a one-cycle strobe from the receiver and
// rx_data_i is valid only in that cycle. There is no ready/backpressure
// path; the loader accepts every strobed byte. we_o is a one-cycle write
// strobe, and addr_o/data_o are valid only while it is high.
interface uart_frame_loader_if #(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_BITS  = 6
);
  logic [7:0]              rx_data_i;
  logic                    rx_ready_i;
  logic                    we_o;
  logic [ADDR_BITS-1:0]    addr_o;
  logic [8*WORD_BYTES-1:0] data_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    error_o;
  logic [2:0]              dbg_state_o;

  // Byte source / status consumer side.
  modport master (
    output rx_data_i, rx_ready_i,
    input  we_o, addr_o, data_o, busy_o, done_o, error_o, dbg_state_o
  );

  // Loader side.
  modport slave (
    input  rx_data_i, rx_ready_i,
    output we_o, addr_o, data_o, busy_o, done_o, error_o, dbg_state_o
  );
endinterface

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: parses framed PROM load packets from a UART byte stream
// (SYNC, ADDR_L, ADDR_H, CNT_L, CNT_H, payload, CSUM), assembles
// little-endian words and issues one-cycle PROM writes.
// Optional feature macro: UART_FRAME_TIMEOUT_EN adds an inter-byte timeout
// that aborts a frame after TIMEOUT_CYCLES idle clocks.
module uart_frame_loader #(
  parameter int         WORD_BYTES     = 2,
  parameter int         ROM_WORDS      = 42,
  parameter int         ADDR_BITS      = 6,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 6250
) (
  input logic               clk,
  input logic               reset,
  uart_frame_loader_if.slave bus
);

  localparam int         DW        = 8 * WORD_BYTES;
  localparam logic [1:0] LANE_LAST = 2'(WORD_BYTES - 1);
  localparam logic [15:0] ROM_END  = 16'(ROM_WORDS);
  localparam logic [15:0] ROM_LAST = 16'(ROM_WORDS - 1);

  // Reject parameter sets the datapath cannot represent.
  if (WORD_BYTES < 1 || WORD_BYTES > 4 || ADDR_BITS > 16 ||
      (2 ** ADDR_BITS) < ROM_WORDS || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_frame_loader: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR0 = 3'd1,
    ADDR1 = 3'd2,
    CNT0  = 3'd3,
    CNT1  = 3'd4,
    DATA  = 3'd5,
    CSUM  = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          addr_q, addr_d;        // start / current word address
  logic [15:0]          cnt_q, cnt_d;          // words remaining
  logic [1:0]           lane_q, lane_d;        // byte lane within current word
  logic [DW-1:0]        word_q, word_d;        // word being assembled
  logic [7:0]           sum_q, sum_d;          // running checksum
  logic                 suppress_q, suppress_d;// frame address out of range
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 busy_q;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]        wr_data_q, wr_data_d;
  logic                 timeout_hit;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;

  // Idle counter: cleared by every byte, runs only while a frame is open.
  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (!bus.rx_ready_i && state_q != IDLE) begin
      if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + TW'(1);
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (reset) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame parser: next state, datapath updates and write strobe generation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    word_d     = word_q;
    sum_d      = sum_q;
    suppress_d = suppress_q;
    done_d     = done_q;
    error_d    = error_q;
    we_d       = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (bus.rx_ready_i) begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx_data_i == SYNC_BYTE) begin
            state_d    = ADDR0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            sum_d      = 8'h00;
            suppress_d = 1'b0;
            lane_d     = 2'd0;
          end
        end
        ADDR0: begin
          addr_d  = {8'h00, bus.rx_data_i};
          sum_d   = sum_q + bus.rx_data_i;
          state_d = ADDR1;
        end
        ADDR1: begin
          addr_d[15:8] = bus.rx_data_i;
          sum_d        = sum_q + bus.rx_data_i;
          state_d      = CNT0;
        end
        CNT0: begin
          cnt_d   = {8'h00, bus.rx_data_i};
          sum_d   = sum_q + bus.rx_data_i;
          state_d = CNT1;
        end
        CNT1: begin
          cnt_d[15:8] = bus.rx_data_i;
          sum_d       = sum_q + bus.rx_data_i;
          suppress_d  = (addr_q >= ROM_END);
          lane_d      = 2'd0;
          state_d     = ({bus.rx_data_i, cnt_q[7:0]} == 16'h0000) ? CSUM : DATA;
        end
        DATA: begin
          // SYNC_BYTE is plain payload here; only the count ends DATA.
          sum_d = sum_q + bus.rx_data_i;
          word_d[8*lane_q +: 8] = bus.rx_data_i;
          if (lane_q == LANE_LAST) begin
            lane_d = 2'd0;
            if (!suppress_q) begin
              we_d      = 1'b1;
              wr_addr_d = addr_q[ADDR_BITS-1:0];
              wr_data_d = word_d;
            end
            addr_d = (addr_q == ROM_LAST) ? 16'h0000 : addr_q + 16'd1;
            cnt_d  = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = CSUM;
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
        CSUM: begin
          if (bus.rx_data_i == sum_q && !suppress_q) begin
            done_d  = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      // Abandon the frame; any partially assembled word is dropped.
      state_d = IDLE;
      error_d = 1'b1;
      done_d  = 1'b0;
      lane_d  = 2'd0;
    end
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      suppress_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      suppress_q <= suppress_d;
      done_q     <= done_d;
      error_q    <= error_d;
      busy_q     <= (state_d != IDLE);
      we_q       <= we_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.we_o        = we_q;
  assign bus.addr_o      = wr_addr_q;
  assign bus.data_o      = wr_data_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.error_o     = error_q;
  assign bus.dbg_state_o = state_q;

endmodule
